// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
//   Shares one single-port memory between the instruction-fetch unit (IF,
//   word reads only) and the load/store unit (D, byte/half/word reads and
//   writes). One operation is issued per cycle. Read data comes back from the
//   memory one cycle after issue and is steered to the requester that owns it.
//
// Parameters
//   ARB_MODE    : 0 = round-robin on conflict, 1 = fixed priority to D
//   CHECK_ALIGN : 1 = reject misaligned IF/D accesses, 0 = pass them through
//
// Ports
//   clk, rst_n                 clock, asynchronous active-low reset
//   if_req/if_addr             fetch request (held until if_gnt)
//   if_gnt                     fetch accepted this cycle (combinational)
//   if_rvalid/if_rdata         fetch response, cycle after grant
//   if_err                     misaligned fetch rejected (registered pulse)
//   d_req/d_we/d_funct3/
//   d_addr/d_wdata             data request (held until d_gnt)
//   d_gnt                      data request accepted this cycle (combinational)
//   d_rvalid/d_rdata           load response, cycle after grant
//   d_err                      misaligned data access rejected (registered pulse)
//   mem_*                      memory command / read-data interface
// -----------------------------------------------------------------------------
module mem_arbiter #(
    parameter bit ARB_MODE    = 1'b0,
    parameter bit CHECK_ALIGN = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_gnt,
    output logic        if_rvalid,
    output logic [31:0] if_rdata,
    output logic        if_err,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [2:0]  d_funct3,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic        d_gnt,
    output logic        d_rvalid,
    output logic [31:0] d_rdata,
    output logic        d_err,
    output logic        mem_write_mem,
    output logic [2:0]  mem_funct3,
    output logic [31:0] mem_write_address,
    output logic [31:0] mem_write_data,
    output logic [31:0] mem_read_address,
    input  logic [31:0] mem_read_data
);

    typedef enum logic [1:0] {
        OWN_NONE = 2'b00,
        OWN_IF   = 2'b01,
        OWN_D    = 2'b10
    } owner_t;

    owner_t rsp_owner_r;
    owner_t rsp_owner_s;
    logic   last_gnt_d_r;   // 1 = D received the most recent grant
    logic   if_err_r;
    logic   d_err_r;

    logic   if_gnt_s;
    logic   d_gnt_s;
    logic   if_mis_s;
    logic   d_mis_s;
    logic   issue_if_s;
    logic   issue_d_s;

    // Fetches are always words.
    function automatic logic if_misaligned(input logic [31:0] addr);
        if_misaligned = CHECK_ALIGN && (addr[1:0] != 2'b00);
    endfunction

    // Size comes from funct3[1:0]: 00 byte, 01 half, 10 word.
    function automatic logic d_misaligned(input logic [2:0] funct3, input logic [31:0] addr);
        logic mis;
        case (funct3[1:0])
            2'b10:   mis = (addr[1:0] != 2'b00);
            2'b01:   mis = addr[0];
            default: mis = 1'b0;
        endcase
        d_misaligned = CHECK_ALIGN && mis;
    endfunction

    assign if_mis_s   = if_misaligned(if_addr);
    assign d_mis_s    = d_misaligned(d_funct3, d_addr);
    assign issue_if_s = if_gnt_s && !if_mis_s;
    assign issue_d_s  = d_gnt_s && !d_mis_s;

    // Grant selection. Grants are masked while reset is asserted so that a
    // write strobe disappears as soon as rst_n falls.
    always_comb begin
        if_gnt_s = 1'b0;
        d_gnt_s  = 1'b0;
        if (!rst_n) begin
            if_gnt_s = 1'b0;
            d_gnt_s  = 1'b0;
        end else if (if_req && d_req) begin
            if (ARB_MODE) begin
                d_gnt_s = 1'b1;
            end else if (last_gnt_d_r) begin
                if_gnt_s = 1'b1;
            end else begin
                d_gnt_s = 1'b1;
            end
        end else begin
            if_gnt_s = if_req;
            d_gnt_s  = d_req;
        end
    end

    assign if_gnt = if_gnt_s;
    assign d_gnt  = d_gnt_s;

    // Memory command for the issued operation; idle values otherwise.
    always_comb begin
        mem_write_mem     = 1'b0;
        mem_funct3        = 3'b010;
        mem_write_address = 32'h0000_0000;
        mem_write_data    = 32'h0000_0000;
        mem_read_address  = 32'h0000_0000;
        if (issue_if_s) begin
            mem_read_address = if_addr;
        end else if (issue_d_s) begin
            mem_funct3       = d_funct3;
            mem_read_address = d_addr;
            if (d_we) begin
                mem_write_mem     = 1'b1;
                mem_write_address = d_addr;
                mem_write_data    = d_wdata;
            end else begin
                mem_write_mem = 1'b0;
            end
        end else begin
            mem_write_mem = 1'b0;
        end
    end

    // Next response owner: only reads that reach memory produce a response.
    always_comb begin
        rsp_owner_s = OWN_NONE;
        if (issue_if_s) begin
            rsp_owner_s = OWN_IF;
        end else if (issue_d_s && !d_we) begin
            rsp_owner_s = OWN_D;
        end else begin
            rsp_owner_s = OWN_NONE;
        end
    end

    // Response owner, arbitration history and error pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_owner_r  <= OWN_NONE;
            last_gnt_d_r <= 1'b1;
            if_err_r     <= 1'b0;
            d_err_r      <= 1'b0;
        end else begin
            rsp_owner_r <= rsp_owner_s;
            if (if_gnt_s || d_gnt_s) begin
                last_gnt_d_r <= d_gnt_s;
            end
            if_err_r <= if_gnt_s && if_mis_s;
            d_err_r  <= d_gnt_s && d_mis_s;
        end
    end

    assign if_rvalid = (rsp_owner_r == OWN_IF);
    assign d_rvalid  = (rsp_owner_r == OWN_D);
    assign if_rdata  = if_rvalid ? mem_read_data : 32'h0000_0000;
    assign d_rdata   = d_rvalid ? mem_read_data : 32'h0000_0000;
    assign if_err    = if_err_r;
    assign d_err     = d_err_r;

endmodule

// File: tb/tb_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_arbiter
//   Drives two arbiters from the same inputs: instance 0 is round-robin with
//   alignment checking, instance 1 is fixed-priority-to-D with no alignment
//   checking. Every cycle each instance is compared against a behavioural
//   model of the arbitration, issue and response rules.
// -----------------------------------------------------------------------------
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        if_req = 1'b0;
    logic [31:0] if_addr = 32'h0;
    logic        d_req = 1'b0;
    logic        d_we = 1'b0;
    logic [2:0]  d_funct3 = 3'b010;
    logic [31:0] d_addr = 32'h0;
    logic [31:0] d_wdata = 32'h0;
    logic [31:0] mem_read_data = 32'h0;

    logic [1:0]  if_gnt_o, if_rvalid_o, if_err_o, d_gnt_o, d_rvalid_o, d_err_o, mem_we_o;
    logic [31:0] if_rdata_o [2];
    logic [31:0] d_rdata_o [2];
    logic [31:0] mem_waddr_o [2];
    logic [31:0] mem_wdata_o [2];
    logic [31:0] mem_raddr_o [2];
    logic [2:0]  mem_f3_o [2];

    int checks = 0;
    int errors = 0;

    // model state per instance
    bit m_last_d [2];
    bit m_if_rv [2];
    bit m_d_rv [2];
    bit m_if_e [2];
    bit m_d_e [2];
    bit n_last_d [2];
    bit n_if_rv [2];
    bit n_d_rv [2];
    bit n_if_e [2];
    bit n_d_e [2];

    always #5 clk = ~clk;

    mem_arbiter #(.ARB_MODE(1'b0), .CHECK_ALIGN(1'b1)) dut_rr (
        .clk(clk), .rst_n(rst_n),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt_o[0]),
        .if_rvalid(if_rvalid_o[0]), .if_rdata(if_rdata_o[0]), .if_err(if_err_o[0]),
        .d_req(d_req), .d_we(d_we), .d_funct3(d_funct3), .d_addr(d_addr),
        .d_wdata(d_wdata), .d_gnt(d_gnt_o[0]), .d_rvalid(d_rvalid_o[0]),
        .d_rdata(d_rdata_o[0]), .d_err(d_err_o[0]),
        .mem_write_mem(mem_we_o[0]), .mem_funct3(mem_f3_o[0]),
        .mem_write_address(mem_waddr_o[0]), .mem_write_data(mem_wdata_o[0]),
        .mem_read_address(mem_raddr_o[0]), .mem_read_data(mem_read_data)
    );

    mem_arbiter #(.ARB_MODE(1'b1), .CHECK_ALIGN(1'b0)) dut_fp (
        .clk(clk), .rst_n(rst_n),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt_o[1]),
        .if_rvalid(if_rvalid_o[1]), .if_rdata(if_rdata_o[1]), .if_err(if_err_o[1]),
        .d_req(d_req), .d_we(d_we), .d_funct3(d_funct3), .d_addr(d_addr),
        .d_wdata(d_wdata), .d_gnt(d_gnt_o[1]), .d_rvalid(d_rvalid_o[1]),
        .d_rdata(d_rdata_o[1]), .d_err(d_err_o[1]),
        .mem_write_mem(mem_we_o[1]), .mem_funct3(mem_f3_o[1]),
        .mem_write_address(mem_waddr_o[1]), .mem_write_data(mem_wdata_o[1]),
        .mem_read_address(mem_raddr_o[1]), .mem_read_data(mem_read_data)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_last_d[i] = 1'b1;
            m_if_rv[i]  = 1'b0;
            m_d_rv[i]   = 1'b0;
            m_if_e[i]   = 1'b0;
            m_d_e[i]    = 1'b0;
        end
    endtask

    // Compare both instances against the model for the current inputs and
    // compute the model state expected after the next clock edge.
    task automatic check_all();
        for (int i = 0; i < 2; i++) begin
            bit          fixed_d;
            bit          align;
            bit          ig;
            bit          dg;
            bit          mis_if;
            bit          mis_d;
            bit          do_if;
            bit          do_d;
            int unsigned size;
            logic [31:0] e_raddr;
            logic [31:0] e_waddr;
            logic [31:0] e_wdata;
            logic [2:0]  e_f3;
            fixed_d = (i == 1);
            align   = (i == 0);
            ig = 1'b0;
            dg = 1'b0;
            if (rst_n) begin
                if (if_req && d_req) begin
                    if (fixed_d || !m_last_d[i]) dg = 1'b1;
                    else ig = 1'b1;
                end else begin
                    ig = if_req;
                    dg = d_req;
                end
            end
            case (d_funct3[1:0])
                2'b10:   size = 4;
                2'b01:   size = 2;
                default: size = 1;
            endcase
            mis_if = align && ((if_addr % 4) != 0);
            mis_d  = align && ((d_addr % size) != 0);
            do_if  = ig && !mis_if;
            do_d   = dg && !mis_d;
            e_raddr = do_if ? if_addr : (do_d ? d_addr : 32'h0);
            e_waddr = (do_d && d_we) ? d_addr : 32'h0;
            e_wdata = (do_d && d_we) ? d_wdata : 32'h0;
            e_f3    = do_d ? d_funct3 : 3'b010;

            check_eq($sformatf("%0d:if_gnt", i), {31'h0, if_gnt_o[i]}, {31'h0, ig});
            check_eq($sformatf("%0d:d_gnt", i), {31'h0, d_gnt_o[i]}, {31'h0, dg});
            check_eq($sformatf("%0d:mem_we", i), {31'h0, mem_we_o[i]}, {31'h0, do_d && d_we});
            check_eq($sformatf("%0d:mem_f3", i), {29'h0, mem_f3_o[i]}, {29'h0, e_f3});
            check_eq($sformatf("%0d:mem_raddr", i), mem_raddr_o[i], e_raddr);
            check_eq($sformatf("%0d:mem_waddr", i), mem_waddr_o[i], e_waddr);
            check_eq($sformatf("%0d:mem_wdata", i), mem_wdata_o[i], e_wdata);
            check_eq($sformatf("%0d:if_rvalid", i), {31'h0, if_rvalid_o[i]}, {31'h0, m_if_rv[i]});
            check_eq($sformatf("%0d:d_rvalid", i), {31'h0, d_rvalid_o[i]}, {31'h0, m_d_rv[i]});
            check_eq($sformatf("%0d:if_rdata", i), if_rdata_o[i], m_if_rv[i] ? mem_read_data : 32'h0);
            check_eq($sformatf("%0d:d_rdata", i), d_rdata_o[i], m_d_rv[i] ? mem_read_data : 32'h0);
            check_eq($sformatf("%0d:if_err", i), {31'h0, if_err_o[i]}, {31'h0, m_if_e[i]});
            check_eq($sformatf("%0d:d_err", i), {31'h0, d_err_o[i]}, {31'h0, m_d_e[i]});

            n_last_d[i] = (ig || dg) ? dg : m_last_d[i];
            n_if_rv[i]  = do_if;
            n_d_rv[i]   = do_d && !d_we;
            n_if_e[i]   = ig && mis_if;
            n_d_e[i]    = dg && mis_d;
        end
    endtask

    // One clock: check after inputs settle, advance the model at the edge,
    // return at the following falling edge ready for new inputs.
    task automatic cycle();
        #1;
        check_all();
        @(posedge clk);
        if (rst_n) begin
            for (int i = 0; i < 2; i++) begin
                m_last_d[i] = n_last_d[i];
                m_if_rv[i]  = n_if_rv[i];
                m_d_rv[i]   = n_d_rv[i];
                m_if_e[i]   = n_if_e[i];
                m_d_e[i]    = n_d_e[i];
            end
        end else begin
            model_reset();
        end
        @(negedge clk);
    endtask

    task automatic set_if(input logic req, input logic [31:0] addr);
        if_req  = req;
        if_addr = addr;
    endtask

    task automatic set_d(input logic req, input logic we, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] wdata);
        d_req    = req;
        d_we     = we;
        d_funct3 = f3;
        d_addr   = addr;
        d_wdata  = wdata;
    endtask

    initial begin
        model_reset();
        @(negedge clk);
        cycle();
        cycle();
        rst_n = 1'b1;

        // idle after reset
        cycle();

        // conflict straight out of reset: round-robin serves IF first
        set_if(1'b1, 32'h0000_0100);
        set_d(1'b1, 1'b0, 3'b010, 32'h0000_0200, 32'h0);
        mem_read_data = 32'h1111_1111;
        cycle();
        set_if(1'b0, 32'h0);
        mem_read_data = 32'h0050_0093;
        cycle();
        set_d(1'b0, 1'b0, 3'b010, 32'h0, 32'h0);
        mem_read_data = 32'h2222_2222;
        cycle();
        cycle();

        // single fetch
        set_if(1'b1, 32'h0000_0100);
        cycle();
        set_if(1'b0, 32'h0);
        mem_read_data = 32'h0050_0093;
        cycle();

        // fixed-priority starvation window: both held, D re-requesting
        set_if(1'b1, 32'h0000_0040);
        for (int k = 0; k < 4; k++) begin
            set_d(1'b1, 1'b0, 3'b010, 32'h0000_0200 + 32'(4 * k), 32'h0);
            mem_read_data = $urandom;
            cycle();
        end
        set_if(1'b0, 32'h0);
        set_d(1'b0, 1'b0, 3'b010, 32'h0, 32'h0);
        cycle();

        // store byte, then misaligned word load, misaligned half, misaligned fetch
        set_d(1'b1, 1'b1, 3'b000, 32'h0000_0203, 32'h0000_00AB);
        cycle();
        set_d(1'b1, 1'b0, 3'b010, 32'h0000_0202, 32'h0);
        cycle();
        set_d(1'b1, 1'b0, 3'b101, 32'h0000_0201, 32'h0);
        mem_read_data = 32'hDEAD_BEEF;
        cycle();
        set_d(1'b0, 1'b0, 3'b010, 32'h0, 32'h0);
        set_if(1'b1, 32'h0000_0102);
        cycle();
        set_if(1'b0, 32'h0);
        cycle();

        // randomized traffic
        for (int k = 0; k < 3000; k++) begin
            set_if($urandom_range(0, 3) != 0, $urandom);
            set_d($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
                  3'($urandom_range(0, 7)), $urandom, $urandom);
            mem_read_data = $urandom;
            cycle();
        end

        // reset during a response, with a store strobe active
        set_if(1'b0, 32'h0);
        set_d(1'b1, 1'b0, 3'b010, 32'h0000_0200, 32'h0);
        cycle();
        set_d(1'b1, 1'b1, 3'b010, 32'h0000_0300, 32'h1234_5678);
        mem_read_data = 32'hCAFE_F00D;
        #1;
        check_all();
        #1;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all();
        check_eq("rst:d_rvalid", {31'h0, d_rvalid_o[0]}, 32'h0);
        check_eq("rst:mem_we", {31'h0, mem_we_o[0]}, 32'h0);
        @(negedge clk);
        cycle();
        rst_n = 1'b1;
        set_d(1'b0, 1'b0, 3'b010, 32'h0, 32'h0);
        set_if(1'b1, 32'h0000_0400);
        cycle();
        set_if(1'b0, 32'h0);
        mem_read_data = 32'h0000_0013;
        cycle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
